// File: rtl/xseq_pkg.sv
// Shared widths, base codes and FSM encoding for the sequence streamer.
package xseq_pkg;

  localparam int unsigned WORD_W         = 24;
  localparam int unsigned BASE_W         = 2;
  localparam int unsigned ADDR_W         = 10;
  localparam int unsigned LEN_W          = 16;
  localparam int unsigned BASES_PER_WORD = WORD_W / BASE_W;
  localparam int unsigned IDX_W          = $clog2(BASES_PER_WORD);

  localparam logic [BASE_W-1:0] BASE_A = 2'b00;
  localparam logic [BASE_W-1:0] BASE_C = 2'b01;
  localparam logic [BASE_W-1:0] BASE_G = 2'b10;
  localparam logic [BASE_W-1:0] BASE_T = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_STREAM,
    S_DONE
  } state_t;

endpackage

// File: rtl/xseq_streamer_if.sv
// Control, memory-read and base-stream signals of the sequence streamer.
interface xseq_streamer_if;
  import xseq_pkg::*;

  logic                start;
  logic [ADDR_W-1:0]   base_addr;
  logic [LEN_W-1:0]    seq_len;
  logic                mem_rd_en;
  logic [ADDR_W-1:0]   mem_addr;
  logic [WORD_W-1:0]   mem_rdata;
  logic [BASE_W-1:0]   base_out;
  logic                base_valid;
  logic                base_ready;
  logic                base_last;
  logic                busy;
  logic                done;

  // streamer side
  modport master (
    input  start, base_addr, seq_len, mem_rdata, base_ready,
    output mem_rd_en, mem_addr, base_out, base_valid, base_last, busy, done
  );

  // memory/array/controller side
  modport slave (
    output start, base_addr, seq_len, mem_rdata, base_ready,
    input  mem_rd_en, mem_addr, base_out, base_valid, base_last, busy, done
  );

endinterface

// File: rtl/xseq_unpack.sv
// Word shift register, base index and one-word prefetch buffer.
module xseq_unpack
  import xseq_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic              fill_i,
  input  logic              adv_i,
  input  logic [WORD_W-1:0] rdata_i,
  output logic [BASE_W-1:0] base_o,
  output logic              cur_vld_o,
  output logic              buf_vld_o,
  output logic [IDX_W-1:0]  idx_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BASES_PER_WORD - 1);

  logic [WORD_W-1:0] sh_q, sh_d;
  logic [WORD_W-1:0] buf_q, buf_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              cur_vld_q, cur_vld_d;
  logic              buf_vld_q, buf_vld_d;

  // Next state: direct load, word-boundary swap from buffer, shift, or buffer fill.
  always_comb begin
    sh_d      = sh_q;
    buf_d     = buf_q;
    idx_d     = idx_q;
    cur_vld_d = cur_vld_q;
    buf_vld_d = buf_vld_q;
    if (clr_i) begin
      sh_d      = '0;
      buf_d     = '0;
      idx_d     = '0;
      cur_vld_d = 1'b0;
      buf_vld_d = 1'b0;
    end else if (load_i) begin
      sh_d      = rdata_i;
      idx_d     = '0;
      cur_vld_d = 1'b1;
    end else if (adv_i && (idx_q == LAST_IDX)) begin
      // Last base of the word leaves: swap in the buffer, or the word landing
      // this very edge, otherwise starve until the pending read returns.
      idx_d = '0;
      if (buf_vld_q) begin
        sh_d      = buf_q;
        buf_vld_d = 1'b0;
      end else if (fill_i) begin
        sh_d = rdata_i;
      end else begin
        cur_vld_d = 1'b0;
      end
    end else begin
      if (adv_i) begin
        sh_d  = {BASE_A, sh_q[WORD_W-1:BASE_W]};
        idx_d = idx_q + IDX_W'(1);
      end
      if (fill_i) begin
        if (!cur_vld_q) begin
          sh_d      = rdata_i;
          idx_d     = '0;
          cur_vld_d = 1'b1;
        end else begin
          buf_d     = rdata_i;
          buf_vld_d = 1'b1;
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sh_q      <= '0;
      buf_q     <= '0;
      idx_q     <= '0;
      cur_vld_q <= 1'b0;
      buf_vld_q <= 1'b0;
    end else begin
      sh_q      <= sh_d;
      buf_q     <= buf_d;
      idx_q     <= idx_d;
      cur_vld_q <= cur_vld_d;
      buf_vld_q <= buf_vld_d;
    end
  end

  assign base_o    = sh_q[BASE_W-1:0];
  assign cur_vld_o = cur_vld_q;
  assign buf_vld_o = buf_vld_q;
  assign idx_o     = idx_q;

endmodule

// File: rtl/xseq_streamer.sv
// Streams packed sequence words from memory to the array, one base per cycle.
module xseq_streamer
  import xseq_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  xseq_streamer_if.master bus
);

  state_t            state_q;
  logic [LEN_W-1:0]  rem_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rd_en_q;
  logic              pend_q;
  logic              busy_q;
  logic              done_q;

  logic [BASE_W-1:0] base;
  logic              cur_vld;
  logic              buf_vld;
  logic [IDX_W-1:0]  idx;
  logic              xfer, final_xfer, need_more, issue, load, fill;

  // Handshake and prefetch decisions from registered state.
  always_comb begin
    xfer       = cur_vld && bus.base_ready;
    final_xfer = (state_q == S_STREAM) && xfer && (rem_q == LEN_W'(1));
    // More bases remain than the current word still holds -> another word is needed.
    need_more  = rem_q > (LEN_W'(BASES_PER_WORD) - LEN_W'(idx));
    issue      = (state_q == S_STREAM) && need_more && !rd_en_q && !pend_q && !buf_vld;
    load       = (state_q == S_WAIT);
    fill       = (state_q == S_STREAM) && pend_q;
  end

  xseq_unpack u_unpack (
    .clk_i     (clk),
    .rst_i     (rst),
    .clr_i     (final_xfer),
    .load_i    (load),
    .fill_i    (fill),
    .adv_i     (xfer),
    .rdata_i   (bus.mem_rdata),
    .base_o    (base),
    .cur_vld_o (cur_vld),
    .buf_vld_o (buf_vld),
    .idx_o     (idx)
  );

  // Sequencing FSM with registered read strobe, address, busy and done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      addr_q  <= '0;
      rd_en_q <= 1'b0;
      pend_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
      pend_q  <= rd_en_q;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.seq_len != '0) begin
              state_q <= S_FETCH;
              rem_q   <= bus.seq_len;
              addr_q  <= bus.base_addr;
              rd_en_q <= 1'b1;
              busy_q  <= 1'b1;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_FETCH: state_q <= S_WAIT;
        S_WAIT:  state_q <= S_STREAM;
        S_STREAM: begin
          if (xfer) begin
            rem_q <= rem_q - LEN_W'(1);
          end
          if (final_xfer) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
          if (issue) begin
            rd_en_q <= 1'b1;
            addr_q  <= addr_q + ADDR_W'(1);
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_rd_en  = rd_en_q;
  assign bus.mem_addr   = addr_q;
  assign bus.base_out   = base;
  assign bus.base_valid = cur_vld;
  assign bus.base_last  = cur_vld && (rem_q == LEN_W'(1));
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_xseq_streamer.sv
// Directed bench for xseq_streamer with a 1-cycle-latency memory model.
module tb_xseq_streamer;
  import xseq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  logic [WORD_W-1:0] mem [1024];
  logic [ADDR_W-1:0] rd_log [$];

  xseq_streamer_if bus ();

  xseq_streamer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Memory returns data exactly one cycle after the read strobe.
  always @(posedge clk) begin
    bus.mem_rdata <= bus.mem_rd_en ? mem[bus.mem_addr] : 24'hBADBAD;
    if (bus.mem_rd_en && !rst) rd_log.push_back(bus.mem_addr);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [BASE_W-1:0] exp_base(input int a, input int i);
    logic [WORD_W-1:0] w;
    w = mem[(a + i / 12) % 1024];
    return w[2 * (i % 12) +: 2];
  endfunction

  // Launch one transfer and check every base, stall stability, latency, done and reads.
  task automatic run_stream(input int addr, input int len, input bit rnd, input bit poke,
                            input string tag);
    int n, cyc, first_v, rd0, nwords;
    logic [BASE_W-1:0] hold_b;
    bit hold_pend;
    rd0 = rd_log.size();
    bus.base_ready = 1'b1;
    bus.start      = 1'b1;
    bus.base_addr  = ADDR_W'(addr);
    bus.seq_len    = LEN_W'(len);
    tick();
    bus.start = 1'b0;
    cyc = 1;
    chk({tag, ".rd_en_c1"}, 32'(bus.mem_rd_en), 32'd1);
    chk({tag, ".addr_c1"},  32'(bus.mem_addr),  32'(addr));
    chk({tag, ".busy_c1"},  32'(bus.busy),      32'd1);
    n = 0; first_v = 0; hold_pend = 0; hold_b = '0;
    while (n < len && cyc < 400) begin
      tick();
      cyc++;
      if (poke) begin
        if (cyc == 5) begin
          bus.start = 1'b1; bus.base_addr = 10'd100; bus.seq_len = 16'd1;
        end
        if (cyc == 7) bus.start = 1'b0;
      end
      if (rnd) bus.base_ready = 1'($urandom_range(0, 1));
      if (hold_pend) begin
        chk({tag, ".valid_held"}, 32'(bus.base_valid), 32'd1);
        chk({tag, ".base_held"},  32'(bus.base_out),   32'(hold_b));
      end
      if (bus.base_valid) begin
        if (first_v == 0) first_v = cyc;
        chk({tag, ".base"}, 32'(bus.base_out),  32'(exp_base(addr, n)));
        chk({tag, ".last"}, 32'(bus.base_last), 32'(n == len - 1));
        hold_pend = !bus.base_ready;
        hold_b    = bus.base_out;
        if (bus.base_ready) n++;
      end else begin
        hold_pend = 0;
      end
    end
    chk({tag, ".count"},   32'(n),       32'(len));
    chk({tag, ".first_v"}, 32'(first_v), 32'd3);
    if (!rnd) chk({tag, ".gapless"}, 32'(cyc), 32'(len + 2));
    tick();
    chk({tag, ".done"},      32'(bus.done),       32'd1);
    chk({tag, ".busy_done"}, 32'(bus.busy),       32'd0);
    chk({tag, ".valid_off"}, 32'(bus.base_valid), 32'd0);
    tick();
    chk({tag, ".done_pulse"}, 32'(bus.done), 32'd0);
    nwords = (len + 11) / 12;
    chk({tag, ".reads"}, 32'(rd_log.size() - rd0), 32'(nwords));
    for (int k = 0; k < nwords && (rd0 + k) < rd_log.size(); k++)
      chk({tag, ".rd_addr"}, 32'(rd_log[rd0 + k]), 32'((addr + k) % 1024));
  endtask

  initial begin
    int rd0;
    for (int i = 0; i < 1024; i++) mem[i] = 24'hBADBAD;
    mem[0]    = 24'hE4E4E4;
    mem[1]    = 24'hE4E4E4;
    mem[4]    = 24'h6C9A5F;
    mem[5]    = 24'h3C0A12;
    mem[1023] = 24'h1B1B1B;
    bus.start = 1'b0; bus.base_addr = '0; bus.seq_len = '0; bus.base_ready = 1'b0;

    // Reset state
    rst = 1'b1;
    tick(); tick();
    chk("rst.valid", 32'(bus.base_valid), 32'd0);
    chk("rst.rd_en", 32'(bus.mem_rd_en),  32'd0);
    chk("rst.busy",  32'(bus.busy),       32'd0);
    chk("rst.done",  32'(bus.done),       32'd0);
    chk("rst.last",  32'(bus.base_last),  32'd0);
    rst = 1'b0;
    tick();

    // Four bases from E4E4E4: 0,1,2,3 in cycles 3-6, done in cycle 7
    run_stream(0, 4, 0, 0, "t2");

    // Two full words, gapless across the boundary
    run_stream(0, 24, 0, 0, "t3");

    // Reset after 5 handshakes, then replay
    bus.base_ready = 1'b1;
    bus.start = 1'b1; bus.base_addr = 10'd0; bus.seq_len = 16'd24;
    tick(); bus.start = 1'b0;
    for (int c = 2; c <= 8; c++) tick();
    chk("t1.base5_pre", 32'(bus.base_out), 32'd1);
    rst = 1'b1;
    tick();
    chk("t1.valid", 32'(bus.base_valid), 32'd0);
    chk("t1.base",  32'(bus.base_out),   32'd0);
    chk("t1.last",  32'(bus.base_last),  32'd0);
    chk("t1.busy",  32'(bus.busy),       32'd0);
    chk("t1.done",  32'(bus.done),       32'd0);
    chk("t1.rd_en", 32'(bus.mem_rd_en),  32'd0);
    chk("t1.addr",  32'(bus.mem_addr),   32'd0);
    rst = 1'b0;
    tick();
    run_stream(0, 24, 0, 0, "t1r");

    // 13 bases with random ready and a start pulse while busy
    run_stream(4, 13, 1, 1, "t4");

    // Address wrap 1023 -> 0
    run_stream(1023, 24, 0, 0, "t5");

    // Zero-length transfer: done in the cycle after start is sampled, no read
    rd0 = rd_log.size();
    bus.start = 1'b1; bus.base_addr = 10'd7; bus.seq_len = 16'd0;
    tick(); bus.start = 1'b0;
    chk("t6.done",  32'(bus.done),      32'd1);
    chk("t6.busy",  32'(bus.busy),      32'd0);
    chk("t6.rd_en", 32'(bus.mem_rd_en), 32'd0);
    tick();
    chk("t6.done_pulse", 32'(bus.done),      32'd0);
    chk("t6.rd_en2",     32'(bus.mem_rd_en), 32'd0);
    chk("t6.reads",      32'(rd_log.size() - rd0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
